id_ex_pipe_reg: RTL and testbench
=================================

// Module: id_ex_pipe_reg
// PURPOSE
//  ID/EX pipeline register, directly downstream of the register file.
//  Captures operands, immediate, register indices and decoded controls for EX.
//  Bypasses same-cycle WB writes; the register file reads old data during a write.
//  Detects load-use hazards, requests an upstream stall and inserts a bubble.
// PARAMETERS
//  XLEN     64  operand/PC/immediate width
//  REG_AW   5   register index width
//  ALUOP_W  2   ALU op field width
// PORTS
//  clk              in   1        rising-edge clock
//  reset            in   1        asynchronous, active-low reset
//  id_valid         in   1        ID holds a real instruction
//  id_pc            in   XLEN     PC of ID instruction
//  id_rs1_data      in   XLEN     register-file ReadData1
//  id_rs2_data      in   XLEN     register-file ReadData2
//  id_imm           in   XLEN     sign-extended immediate
//  id_rs1,id_rs2    in   REG_AW   source indices
//  id_rd            in   REG_AW   destination index
//  id_reg_write,id_mem_read,id_mem_write,id_mem_to_reg,id_alu_src,id_branch  in 1  decoded controls
//  id_alu_op        in   ALUOP_W  ALU op
//  wb_reg_write     in   1        WB writing register file this cycle
//  wb_rd            in   REG_AW   WB destination
//  wb_write_data    in   XLEN     WB data
//  flush            in   1        branch taken in EX: kill ID instruction
//  ex_stall         in   1        downstream stall: hold all EX outputs
//  hazard_stall     out  1        load-use detected: freeze PC and IF/ID
//  ex_valid         out  1        EX slot holds a real instruction
//  ex_pc,ex_rs1_data,ex_rs2_data,ex_imm  out XLEN   registered copies
//  ex_rs1,ex_rs2,ex_rd            out REG_AW          registered indices
//  ex_reg_write,ex_mem_read,ex_mem_write,ex_mem_to_reg,ex_alu_src,ex_branch out 1
//  ex_alu_op        out  ALUOP_W
// BEHAVIOUR
//  - Reset low (async): every registered output is 0, including ex_valid and all controls.
//    Reset release is seen at the next clk edge.
//  - Latency: 1 cycle. ID values present before edge N appear on ex_* after edge N.
//  - Bypass (combinational, before the capture):
//    rsX operand = wb_write_data if wb_reg_write && wb_rd!=0 && wb_rd==id_rsX,
//    else id_rsX_data. Applied to rs1 and rs2 independently.
//  - Load-use hazard (combinational):
//    hz = ex_valid && ex_mem_read && ex_rd!=0 && id_valid
//         && (ex_rd==id_rs1 || ex_rd==id_rs2).
//    hazard_stall = hz && !flush && !ex_stall.
//  - Priority at each posedge (highest first):
//    1 flush     : load bubble (ex_valid=0, all six 1-bit controls=0, ex_alu_op=0); data fields don't-care, drive 0
//    2 ex_stall  : hold every output unchanged
//    3 hz        : load bubble as in 1
//    4 otherwise : load the ID instruction; ex_valid=id_valid; controls gated to 0 when id_valid=0
//  - flush together with ex_stall: the flush wins, because a killed instruction must not survive the hold.
//  - Index 0 never triggers the bypass or the hazard.
//  - hazard_stall lasts exactly one cycle per load-use pair.
//    After the bubble, ex_mem_read=0, so the held ID instruction advances on the next edge.
//  - Reset asserted mid-stall clears the bubble or hold state immediately, and hazard_stall falls to 0 through ex_valid=0.
// TESTING
//  1 Reset: drive all inputs nonzero, pull reset low between edges
//    -> every ex_* reads 0 at once, with no clk edge; hazard_stall=0.
//  2 Pass-through: id_pc=0x100, rs1_data=0x2A, imm=-4, rd=5, reg_write=1, valid=1
//    -> next cycle ex_pc=0x100, ex_rs1_data=0x2A, ex_imm=0xFFFF_FFFF_FFFF_FFFC, ex_rd=5, ex_valid=1.
//  3 WB bypass: id_rs1=7, id_rs1_data=0x0E, wb_reg_write=1, wb_rd=7, wb_write_data=0xDEAD
//    -> ex_rs1_data=0xDEAD. Repeat with wb_rd=0 and id_rs1=0 -> ex_rs1_data=0x0E.
//  4 Load-use: EX holds ld x3 (mem_read=1, rd=3); ID has add with rs2=3
//    -> hazard_stall=1 for one cycle, then ex_valid=0 with zero controls.
//    On the following edge the add enters EX with ex_rs2=3.
//  5 Flush vs stall: assert flush and ex_stall together with a valid ID instruction
//    -> bubble on the next edge. ex_stall alone for 3 cycles -> outputs bit-identical throughout.
//  6 Hazard masked: EX rd=0 with mem_read=1 and id_rs1=0 -> hazard_stall=0, normal load.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: captures operands, immediate, indices and decoded
// controls for EX, with WB write bypass and load-use bubble insertion.
module id_ex_pipe_reg #(
  parameter int XLEN    = 64,
  parameter int REG_AW  = 5,
  parameter int ALUOP_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [XLEN-1:0]    id_pc,
  input  logic [XLEN-1:0]    id_rs1_data,
  input  logic [XLEN-1:0]    id_rs2_data,
  input  logic [XLEN-1:0]    id_imm,
  input  logic [REG_AW-1:0]  id_rs1,
  input  logic [REG_AW-1:0]  id_rs2,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic               id_reg_write,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               id_mem_to_reg,
  input  logic               id_alu_src,
  input  logic               id_branch,
  input  logic [ALUOP_W-1:0] id_alu_op,
  input  logic               wb_reg_write,
  input  logic [REG_AW-1:0]  wb_rd,
  input  logic [XLEN-1:0]    wb_write_data,
  input  logic               flush,
  input  logic               ex_stall,
  output logic               hazard_stall,
  output logic               ex_valid,
  output logic [XLEN-1:0]    ex_pc,
  output logic [XLEN-1:0]    ex_rs1_data,
  output logic [XLEN-1:0]    ex_rs2_data,
  output logic [XLEN-1:0]    ex_imm,
  output logic [REG_AW-1:0]  ex_rs1,
  output logic [REG_AW-1:0]  ex_rs2,
  output logic [REG_AW-1:0]  ex_rd,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_mem_to_reg,
  output logic               ex_alu_src,
  output logic               ex_branch,
  output logic [ALUOP_W-1:0] ex_alu_op
);

  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;
  logic            wb_hit1;
  logic            wb_hit2;
  logic            hz;
  logic            bubble;

  // The register file returns stale data while WB writes the same index.
  assign wb_hit1 = wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs1);
  assign wb_hit2 = wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs2);
  assign rs1_fwd = wb_hit1 ? wb_write_data : id_rs1_data;
  assign rs2_fwd = wb_hit2 ? wb_write_data : id_rs2_data;

  assign hz = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid &&
              ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  assign hazard_stall = hz && !flush && !ex_stall;
  // Flush overrides a downstream hold so a killed instruction cannot linger.
  assign bubble       = flush || (hz && !ex_stall);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid      <= 1'b0;
      ex_pc         <= '0;
      ex_rs1_data   <= '0;
      ex_rs2_data   <= '0;
      ex_imm        <= '0;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_rd         <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_branch     <= 1'b0;
      ex_alu_op     <= '0;
    end else if (bubble) begin
      ex_valid      <= 1'b0;
      ex_pc         <= '0;
      ex_rs1_data   <= '0;
      ex_rs2_data   <= '0;
      ex_imm        <= '0;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_rd         <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_alu_src    <= 1'b0;
      ex_branch     <= 1'b0;
      ex_alu_op     <= '0;
    end else if (!ex_stall) begin
      ex_valid      <= id_valid;
      ex_pc         <= id_pc;
      ex_rs1_data   <= rs1_fwd;
      ex_rs2_data   <= rs2_fwd;
      ex_imm        <= id_imm;
      ex_rs1        <= id_rs1;
      ex_rs2        <= id_rs2;
      ex_rd         <= id_rd;
      ex_reg_write  <= id_valid && id_reg_write;
      ex_mem_read   <= id_valid && id_mem_read;
      ex_mem_write  <= id_valid && id_mem_write;
      ex_mem_to_reg <= id_valid && id_mem_to_reg;
      ex_alu_src    <= id_valid && id_alu_src;
      ex_branch     <= id_valid && id_branch;
      ex_alu_op     <= id_valid ? id_alu_op : '0;
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: directed scenarios plus randomized
// traffic compared against a behavioural model of the EX slot.
module tb_id_ex_pipe_reg;
  localparam int XLEN = 64, REG_AW = 5, ALUOP_W = 2;

  logic clk = 1'b0, reset = 1'b0;
  logic id_valid, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_branch;
  logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm, wb_write_data;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd, wb_rd;
  logic [ALUOP_W-1:0] id_alu_op;
  logic wb_reg_write, flush, ex_stall;
  logic hazard_stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch;
  logic [XLEN-1:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
  logic [ALUOP_W-1:0] ex_alu_op;

  int vectors = 0;
  int miscompares = 0;

  // Expected content of the EX slot.
  typedef struct {
    logic valid;
    logic [XLEN-1:0] pc, a, b, imm;
    logic [REG_AW-1:0] rs1, rs2, rd;
    logic [5:0] ctl;  // reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch
    logic [ALUOP_W-1:0] op;
  } slot_t;
  slot_t m;

  id_ex_pipe_reg #(.XLEN(XLEN), .REG_AW(REG_AW), .ALUOP_W(ALUOP_W)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src), .id_branch(id_branch),
    .id_alu_op(id_alu_op), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_write_data(wb_write_data), .flush(flush), .ex_stall(ex_stall),
    .hazard_stall(hazard_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src), .ex_branch(ex_branch),
    .ex_alu_op(ex_alu_op)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic slot_t empty_slot();
    slot_t s;
    s.valid = 1'b0; s.pc = '0; s.a = '0; s.b = '0; s.imm = '0;
    s.rs1 = '0; s.rs2 = '0; s.rd = '0; s.ctl = '0; s.op = '0;
    return s;
  endfunction

  // A load in EX whose destination an ID source names (x0 excluded).
  function automatic logic model_load_use();
    return m.valid && m.ctl[4] && (m.rd != 0) && id_valid && (m.rd == id_rs1 || m.rd == id_rs2);
  endfunction

  function automatic slot_t model_next();
    slot_t s;
    if (flush) return empty_slot();
    if (ex_stall) return m;
    if (model_load_use()) return empty_slot();
    s.valid = id_valid;
    s.pc = id_pc;
    s.imm = id_imm;
    s.rs1 = id_rs1; s.rs2 = id_rs2; s.rd = id_rd;
    s.a = (wb_reg_write && wb_rd != 0 && wb_rd == id_rs1) ? wb_write_data : id_rs1_data;
    s.b = (wb_reg_write && wb_rd != 0 && wb_rd == id_rs2) ? wb_write_data : id_rs2_data;
    s.ctl = id_valid ? {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_branch} : 6'b0;
    s.op = id_valid ? id_alu_op : '0;
    return s;
  endfunction

  task automatic compare_slot(input string tag);
    check({tag, ".valid"}, ex_valid, m.valid);
    check({tag, ".pc"}, ex_pc, m.pc);
    check({tag, ".rs1_data"}, ex_rs1_data, m.a);
    check({tag, ".rs2_data"}, ex_rs2_data, m.b);
    check({tag, ".imm"}, ex_imm, m.imm);
    check({tag, ".rs1"}, ex_rs1, m.rs1);
    check({tag, ".rs2"}, ex_rs2, m.rs2);
    check({tag, ".rd"}, ex_rd, m.rd);
    check({tag, ".ctl"}, {ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch}, m.ctl);
    check({tag, ".alu_op"}, ex_alu_op, m.op);
  endtask

  // Inputs must already be driven; checks hazard_stall, clocks, checks the slot.
  task automatic step(input string tag);
    logic exp_hs;
    #1;
    exp_hs = model_load_use() && !flush && !ex_stall;
    check({tag, ".hazard_stall"}, hazard_stall, exp_hs);
    m = model_next();
    @(posedge clk);
    #1;
    compare_slot(tag);
  endtask

  task automatic set_id(input logic v, input logic [63:0] pc, input logic [REG_AW-1:0] r1,
                        input logic [REG_AW-1:0] r2, input logic [REG_AW-1:0] rd,
                        input logic mr, input logic rw);
    id_valid = v; id_pc = pc; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
    id_mem_read = mr; id_reg_write = rw;
    id_mem_write = 1'b0; id_mem_to_reg = mr; id_alu_src = mr; id_branch = 1'b0;
    id_alu_op = 2'd0; id_rs1_data = 64'h11; id_rs2_data = 64'h22; id_imm = 64'h8;
  endtask

  initial begin
    // Test 1: reset, then async reset while a load-use stall is pending.
    set_id(1, 64'h40, 5'd1, 5'd2, 5'd3, 1, 1);
    wb_reg_write = 0; wb_rd = 0; wb_write_data = 0; flush = 0; ex_stall = 0;
    m = empty_slot();
    repeat (2) @(posedge clk);
    #1;
    compare_slot("reset_hold");
    check("reset_hold.hazard_stall", hazard_stall, 1'b0);
    reset = 1'b1;
    step("ld_x3");                                  // EX now holds ld x3
    set_id(1, 64'h44, 5'd3, 5'd3, 5'd9, 1, 1);
    id_mem_write = 1; id_branch = 1; id_alu_op = 2'd3; flush = 0;
    wb_reg_write = 1; wb_rd = 5'd4; wb_write_data = 64'hFFFF;
    #1;
    check("pre_reset.hazard_stall", hazard_stall, 1'b1);
    reset = 1'b0;
    #1;
    m = empty_slot();
    compare_slot("async_reset");
    check("async_reset.hazard_stall", hazard_stall, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    wb_reg_write = 0;

    // Test 2: pass-through.
    set_id(1, 64'h100, 5'd1, 5'd2, 5'd5, 0, 1);
    id_rs1_data = 64'h2A; id_imm = -64'sd4;
    step("pass");
    check("pass.pc_const", ex_pc, 64'h100);
    check("pass.rs1_const", ex_rs1_data, 64'h2A);
    check("pass.imm_const", ex_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    check("pass.rd_const", ex_rd, 5'd5);
    check("pass.valid_const", ex_valid, 1'b1);

    // Test 3: WB bypass, then x0 never bypasses.
    set_id(1, 64'h104, 5'd7, 5'd2, 5'd6, 0, 1);
    id_rs1_data = 64'h0E; wb_reg_write = 1; wb_rd = 5'd7; wb_write_data = 64'hDEAD;
    step("bypass");
    check("bypass.const", ex_rs1_data, 64'hDEAD);
    set_id(1, 64'h108, 5'd0, 5'd2, 5'd6, 0, 1);
    id_rs1_data = 64'h0E; wb_rd = 5'd0;
    step("bypass_x0");
    check("bypass_x0.const", ex_rs1_data, 64'h0E);
    wb_reg_write = 0;

    // Test 4: load-use bubble, then the dependent add enters EX.
    set_id(1, 64'h10C, 5'd1, 5'd2, 5'd3, 1, 1);
    step("lu_ld");
    set_id(1, 64'h110, 5'd4, 5'd3, 5'd8, 0, 1);
    #1;
    check("lu.stall_const", hazard_stall, 1'b1);
    step("lu_bubble");
    check("lu_bubble.valid_const", ex_valid, 1'b0);
    step("lu_add");
    check("lu_add.rs2_const", ex_rs2, 5'd3);
    check("lu_add.valid_const", ex_valid, 1'b1);

    // Test 5: flush beats stall; stall alone holds for 3 cycles.
    set_id(1, 64'h114, 5'd1, 5'd2, 5'd10, 0, 1);
    flush = 1; ex_stall = 1;
    step("flush_stall");
    check("flush_stall.valid_const", ex_valid, 1'b0);
    flush = 0; ex_stall = 0;
    step("pre_hold");
    ex_stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, 64'h200 + 64'(i), 5'd10, 5'd10, 5'd1, 1, 1);
      step("hold");
    end
    ex_stall = 0;

    // Test 6: load to x0 never creates a hazard.
    set_id(1, 64'h300, 5'd1, 5'd2, 5'd0, 1, 1);
    step("ld_x0");
    set_id(1, 64'h304, 5'd0, 5'd0, 5'd4, 0, 1);
    #1;
    check("mask.stall_const", hazard_stall, 1'b0);
    step("mask");

    // Randomized traffic with small index ranges to force collisions.
    for (int n = 0; n < 400; n++) begin
      id_valid = ($urandom_range(0, 7) != 0);
      id_pc = {$urandom, $urandom}; id_imm = {$urandom, $urandom};
      id_rs1_data = {$urandom, $urandom}; id_rs2_data = {$urandom, $urandom};
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      id_rd = 5'($urandom_range(0, 3));
      {id_reg_write, id_mem_write, id_mem_to_reg, id_alu_src, id_branch} = 5'($urandom);
      id_mem_read = ($urandom_range(0, 1) == 1);
      id_alu_op = 2'($urandom);
      wb_reg_write = ($urandom_range(0, 1) == 1); wb_rd = 5'($urandom_range(0, 3));
      wb_write_data = {$urandom, $urandom};
      flush = ($urandom_range(0, 15) == 0);
      ex_stall = ($urandom_range(0, 5) == 0);
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
